// File: rtl/block_scheduler.sv
// Block scheduler: sequences one 2**IDX_W x 2**IDX_W block through LOAD, CALC and DRAIN.
// Optional macro ZIGZAG_ORDER_EN selects JPEG zigzag drain order (IDX_W must be 3); default drains in raster order.
module block_scheduler #(
    parameter int IDX_W       = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             buf_we,
    output logic [IDX_W-1:0] buf_u,
    output logic [IDX_W-1:0] buf_v,
    output logic             dp_go,
    input  logic             dp_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_u,
    output logic [IDX_W-1:0] out_v,
    output logic             busy,
    output logic             blk_done,
    output logic             err
);
    localparam int K_W = 2 * IDX_W;
    localparam int T_W = $clog2(TIMEOUT_CYC);
    localparam logic [K_W-1:0] K_LAST = {K_W{1'b1}};
    localparam logic [K_W-1:0] K_ONE  = K_W'(1'b1);
    localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT_CYC - 1);
    localparam logic [T_W-1:0] T_ONE  = T_W'(1'b1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CALC  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t         state_r;
    logic [K_W-1:0] k_r;
    logic [T_W-1:0] tcnt_r;
    logic           load_beat_s;
    logic           drain_beat_s;

`ifdef ZIGZAG_ORDER_EN
    if (IDX_W != 3) begin : g_zz_width_check
        $error("block_scheduler: ZIGZAG_ORDER_EN requires IDX_W == 3");
    end

    // Zigzag LUT: octal literal digits are {u, v}.
    function automatic logic [K_W-1:0] drain_addr(input logic [K_W-1:0] idx);
        case (idx)
            6'd0:  drain_addr = 6'o00; 6'd1:  drain_addr = 6'o01; 6'd2:  drain_addr = 6'o10; 6'd3:  drain_addr = 6'o20;
            6'd4:  drain_addr = 6'o11; 6'd5:  drain_addr = 6'o02; 6'd6:  drain_addr = 6'o03; 6'd7:  drain_addr = 6'o12;
            6'd8:  drain_addr = 6'o21; 6'd9:  drain_addr = 6'o30; 6'd10: drain_addr = 6'o40; 6'd11: drain_addr = 6'o31;
            6'd12: drain_addr = 6'o22; 6'd13: drain_addr = 6'o13; 6'd14: drain_addr = 6'o04; 6'd15: drain_addr = 6'o05;
            6'd16: drain_addr = 6'o14; 6'd17: drain_addr = 6'o23; 6'd18: drain_addr = 6'o32; 6'd19: drain_addr = 6'o41;
            6'd20: drain_addr = 6'o50; 6'd21: drain_addr = 6'o60; 6'd22: drain_addr = 6'o51; 6'd23: drain_addr = 6'o42;
            6'd24: drain_addr = 6'o33; 6'd25: drain_addr = 6'o24; 6'd26: drain_addr = 6'o15; 6'd27: drain_addr = 6'o06;
            6'd28: drain_addr = 6'o07; 6'd29: drain_addr = 6'o16; 6'd30: drain_addr = 6'o25; 6'd31: drain_addr = 6'o34;
            6'd32: drain_addr = 6'o43; 6'd33: drain_addr = 6'o52; 6'd34: drain_addr = 6'o61; 6'd35: drain_addr = 6'o70;
            6'd36: drain_addr = 6'o71; 6'd37: drain_addr = 6'o62; 6'd38: drain_addr = 6'o53; 6'd39: drain_addr = 6'o44;
            6'd40: drain_addr = 6'o35; 6'd41: drain_addr = 6'o26; 6'd42: drain_addr = 6'o17; 6'd43: drain_addr = 6'o27;
            6'd44: drain_addr = 6'o36; 6'd45: drain_addr = 6'o45; 6'd46: drain_addr = 6'o54; 6'd47: drain_addr = 6'o63;
            6'd48: drain_addr = 6'o72; 6'd49: drain_addr = 6'o73; 6'd50: drain_addr = 6'o64; 6'd51: drain_addr = 6'o55;
            6'd52: drain_addr = 6'o46; 6'd53: drain_addr = 6'o37; 6'd54: drain_addr = 6'o47; 6'd55: drain_addr = 6'o56;
            6'd56: drain_addr = 6'o65; 6'd57: drain_addr = 6'o74; 6'd58: drain_addr = 6'o75; 6'd59: drain_addr = 6'o66;
            6'd60: drain_addr = 6'o57; 6'd61: drain_addr = 6'o67; 6'd62: drain_addr = 6'o76; 6'd63: drain_addr = 6'o77;
            default: drain_addr = 6'o00;
        endcase
    endfunction
`else
    function automatic logic [K_W-1:0] drain_addr(input logic [K_W-1:0] idx);
        drain_addr = idx;
    endfunction
`endif

    assign buf_we       = in_valid & in_ready;
    assign load_beat_s  = buf_we;
    assign drain_beat_s = out_valid & out_ready;
    assign buf_u        = k_r[K_W-1:IDX_W];
    assign buf_v        = k_r[IDX_W-1:0];

    // Phase sequencing, shared block index and all registered status/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            k_r       <= '0;
            tcnt_r    <= '0;
            in_ready  <= 1'b0;
            dp_go     <= 1'b0;
            out_valid <= 1'b0;
            out_u     <= '0;
            out_v     <= '0;
            busy      <= 1'b0;
            blk_done  <= 1'b0;
            err       <= 1'b0;
        end else begin
            dp_go    <= 1'b0;
            blk_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= LOAD;
                        k_r      <= '0;
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_beat_s) begin
                        if (k_r == K_LAST) begin
                            state_r  <= CALC;
                            k_r      <= '0;
                            tcnt_r   <= '0;
                            in_ready <= 1'b0;
                            dp_go    <= 1'b1;
                        end else begin
                            k_r <= k_r + K_ONE;
                        end
                    end
                end
                CALC: begin
                    // dp_done takes priority over a timeout landing in the same cycle.
                    if (dp_done) begin
                        state_r        <= DRAIN;
                        k_r            <= '0;
                        tcnt_r         <= '0;
                        out_valid      <= 1'b1;
                        {out_u, out_v} <= drain_addr('0);
                    end else if (tcnt_r == T_LAST) begin
                        state_r <= IDLE;
                        tcnt_r  <= '0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        tcnt_r <= tcnt_r + T_ONE;
                    end
                end
                DRAIN: begin
                    if (drain_beat_s) begin
                        if (k_r == K_LAST) begin
                            state_r   <= IDLE;
                            k_r       <= '0;
                            out_valid <= 1'b0;
                            out_u     <= '0;
                            out_v     <= '0;
                            busy      <= 1'b0;
                            blk_done  <= 1'b1;
                        end else begin
                            k_r            <= k_r + K_ONE;
                            {out_u, out_v} <= drain_addr(k_r + K_ONE);
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    k_r       <= '0;
                    tcnt_r    <= '0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_block_scheduler.sv
// Self-checking bench for block_scheduler: randomized handshakes checked against a transaction-level model.
module tb_block_scheduler;
    logic       clk, rst, start, in_valid, in_ready, buf_we;
    logic [2:0] buf_u, buf_v, out_u, out_v;
    logic       dp_go, dp_done, out_valid, out_ready, busy, blk_done, err;

    int tests_run = 0;
    int tests_failed = 0;

    // Observations gathered by run_block for the calling test to judge.
    logic [5:0] wr_q[$];
    logic [5:0] rd_q[$];
    logic [5:0] exp_rd[64];
    int         n_go, n_done, stall_bad;
    logic       obs_err1, obs_busy1;

    block_scheduler #(.IDX_W(3), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .buf_we(buf_we), .buf_u(buf_u), .buf_v(buf_v), .dp_go(dp_go), .dp_done(dp_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_u(out_u), .out_v(out_v),
        .busy(busy), .blk_done(blk_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected drain order: zigzag walks anti-diagonals u+v=s, alternating direction.
    function automatic void build_drain_order();
        int n;
        int u;
        int v;
        n = 0;
`ifdef ZIGZAG_ORDER_EN
        for (int s = 0; s < 15; s++) begin
            for (int j = 0; j < 8; j++) begin
                u = (s % 2 == 1) ? j : 7 - j;
                v = s - u;
                if (v >= 0 && v < 8) begin
                    exp_rd[n] = {u[2:0], v[2:0]};
                    n++;
                end
            end
        end
`else
        for (int i = 0; i < 64; i++) begin
            u = i / 8;
            v = i % 8;
            exp_rd[i] = {u[2:0], v[2:0]};
        end
`endif
    endfunction

    // Drives one block from start to blk_done and records writes, handshakes, pulses and stalls.
    task automatic run_block(input int iv_pct, input int or_mode, input int dp_delay,
                             input bit noise, input bit hold_start, output int cycles);
        bit         armed, given, have_stall, tog;
        int         since_go;
        logic [5:0] stall_addr;
        wr_q.delete();
        rd_q.delete();
        n_go = 0; n_done = 0; stall_bad = 0; obs_err1 = 1'bx; obs_busy1 = 1'bx;
        armed = 1'b0; given = 1'b0; have_stall = 1'b0; tog = 1'b0; since_go = 0; cycles = 0;
        stall_addr = 6'd0;
        start = 1'b1;
        in_valid = ($urandom_range(99) < iv_pct);
        out_ready = 1'b1;
        dp_done = 1'b0;
        while (cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) begin
                obs_err1 = err;
                obs_busy1 = busy;
            end
            if (blk_done) n_done++;
            if (dp_go) begin
                n_go++;
                armed = 1'b1;
                since_go = 0;
            end else if (armed) begin
                since_go++;
            end
            if (blk_done) break;
            start = hold_start ? 1'b1 : (noise ? 1'($urandom_range(1)) : 1'b0);
            in_valid = ($urandom_range(99) < iv_pct);
            case (or_mode)
                0: out_ready = 1'b1;
                1: begin tog = ~tog; out_ready = tog; end
                default: out_ready = 1'($urandom_range(1));
            endcase
            if (armed && !given) begin
                dp_done = (since_go == dp_delay);
                given = dp_done;
            end else begin
                dp_done = noise ? 1'($urandom_range(1)) : 1'b0;
            end
            #1;
            if (buf_we) wr_q.push_back({buf_u, buf_v});
            if (have_stall && (!out_valid || {out_u, out_v} !== stall_addr)) stall_bad++;
            have_stall = out_valid && !out_ready;
            stall_addr = {out_u, out_v};
            if (out_valid && out_ready) rd_q.push_back({out_u, out_v});
        end
        if (!hold_start) start = 1'b0;
        dp_done = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, in_ready, out_valid, dp_go, blk_done, err} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 000000", {busy, in_ready, out_valid, dp_go, blk_done, err});
        end
        tests_run++;
        if ({buf_u, buf_v, out_u, out_v} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_addr: got %h, expected 000", {buf_u, buf_v, out_u, out_v});
        end
        rst = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({busy, in_ready, buf_we} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_no_write: busy/in_ready/buf_we got %b, expected 000", {busy, in_ready, buf_we});
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_block();
        int cyc, bad_w, bad_r;
        run_block(100, 0, 1, 1'b0, 1'b0, cyc);
        bad_w = 0;
        foreach (wr_q[i]) if (i < 64 && wr_q[i] !== {3'(i / 8), 3'(i % 8)}) bad_w++;
        bad_r = 0;
        foreach (rd_q[i]) if (i < 64 && rd_q[i] !== exp_rd[i]) bad_r++;
        tests_run++;
        if (wr_q.size() !== 64 || bad_w !== 0) begin
            tests_failed++;
            $display("FAIL full_writes: got %0d beats with %0d wrong, expected 64 with 0 wrong", wr_q.size(), bad_w);
        end
        tests_run++;
        if (rd_q.size() !== 64 || bad_r !== 0) begin
            tests_failed++;
            $display("FAIL full_reads: got %0d beats with %0d wrong, expected 64 with 0 wrong", rd_q.size(), bad_r);
        end
        tests_run++;
        if (((rd_q.size() == 64) ? rd_q[63] : 6'bx) !== exp_rd[63]) begin
            tests_failed++;
            $display("FAIL full_last_addr: got %o, expected %o", (rd_q.size() == 64) ? rd_q[63] : 6'bx, exp_rd[63]);
        end
        tests_run++;
        if (n_go !== 1) begin
            tests_failed++;
            $display("FAIL full_dp_go: got %0d pulses, expected 1", n_go);
        end
        tests_run++;
        if (cyc !== 131) begin
            tests_failed++;
            $display("FAIL full_latency: got %0d cycles, expected 131", cyc);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({blk_done, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL full_done_once: blk_done/busy got %b, expected 00", {blk_done, busy});
        end
    endtask

    task automatic test_stall();
        int cyc, bad_r;
        run_block(100, 1, 1, 1'b0, 1'b0, cyc);
        bad_r = 0;
        foreach (rd_q[i]) if (i < 64 && rd_q[i] !== exp_rd[i]) bad_r++;
        tests_run++;
        if (rd_q.size() !== 64 || bad_r !== 0) begin
            tests_failed++;
            $display("FAIL stall_reads: got %0d beats with %0d wrong, expected 64 with 0 wrong", rd_q.size(), bad_r);
        end
        tests_run++;
        if (stall_bad !== 0) begin
            tests_failed++;
            $display("FAIL stall_hold: got %0d unstable stall cycles, expected 0", stall_bad);
        end
        // DRAIN opens on a ready cycle; each of the later 63 handshakes follows one stall.
        tests_run++;
        if (cyc !== 131 + 63) begin
            tests_failed++;
            $display("FAIL stall_latency: got %0d cycles, expected %0d", cyc, 131 + 63);
        end
    endtask

    task automatic test_timeout();
        int calc, cyc;
        bit seen_go, seen_done;
        start = 1'b1; in_valid = 1'b1; dp_done = 1'b0; out_ready = 1'b1;
        seen_go = 1'b0; seen_done = 1'b0; calc = 1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dp_go) begin seen_go = 1'b1; break; end
            @(posedge clk); #1;
        end
        tests_run++;
        if (seen_go !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_go: dp_go seen %0d, expected 1", seen_go);
        end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (blk_done) seen_done = 1'b1;
            if (!busy) break;
            calc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (calc !== 16) begin
            tests_failed++;
            $display("FAIL timeout_len: got %0d CALC cycles, expected 16", calc);
        end
        tests_run++;
        if ({err, seen_done} !== 2'b10) begin
            tests_failed++;
            $display("FAIL timeout_flags: err/blk_done got %b, expected 10", {err, seen_done});
        end
        @(posedge clk); #1;
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_sticky: err got %b, expected 1", err);
        end
        run_block(100, 0, 1, 1'b0, 1'b0, cyc);
        tests_run++;
        if ({obs_err1, obs_busy1} !== 2'b01 || n_done !== 1) begin
            tests_failed++;
            $display("FAIL timeout_restart: err/busy got %b, blk_done %0d, expected 01 and 1", {obs_err1, obs_busy1}, n_done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc1, cyc2, bad_w;
        run_block(60, 0, 1, 1'b0, 1'b1, cyc1);
        bad_w = 0;
        foreach (wr_q[i]) if (i < 64 && wr_q[i] !== {3'(i / 8), 3'(i % 8)}) bad_w++;
        tests_run++;
        if (wr_q.size() !== 64 || bad_w !== 0 || n_go !== 1 || n_done !== 1) begin
            tests_failed++;
            $display("FAIL b2b_first: beats %0d wrong %0d go %0d done %0d, expected 64 0 1 1", wr_q.size(), bad_w, n_go, n_done);
        end
        run_block(60, 2, 2, 1'b0, 1'b0, cyc2);
        bad_w = 0;
        foreach (wr_q[i]) if (i < 64 && wr_q[i] !== {3'(i / 8), 3'(i % 8)}) bad_w++;
        tests_run++;
        if (obs_busy1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_accept: busy after blk_done-cycle start got %b, expected 1", obs_busy1);
        end
        tests_run++;
        if (wr_q.size() !== 64 || bad_w !== 0 || rd_q.size() !== 64 || n_done !== 1) begin
            tests_failed++;
            $display("FAIL b2b_second: writes %0d wrong %0d reads %0d done %0d, expected 64 0 64 1", wr_q.size(), bad_w, rd_q.size(), n_done);
        end
    endtask

    task automatic test_random();
        int cyc, bad_w, bad_r;
        for (int b = 0; b < 4; b++) begin
            run_block(30 + int'($urandom_range(70)), 2, 1 + int'($urandom_range(11)), 1'b1, 1'b0, cyc);
            bad_w = 0;
            foreach (wr_q[i]) if (i < 64 && wr_q[i] !== {3'(i / 8), 3'(i % 8)}) bad_w++;
            bad_r = 0;
            foreach (rd_q[i]) if (i < 64 && rd_q[i] !== exp_rd[i]) bad_r++;
            tests_run++;
            if (wr_q.size() !== 64 || bad_w !== 0 || rd_q.size() !== 64 || bad_r !== 0) begin
                tests_failed++;
                $display("FAIL rand%0d_seq: writes %0d/%0d wrong, reads %0d/%0d wrong, expected 64/0 and 64/0", b, wr_q.size(), bad_w, rd_q.size(), bad_r);
            end
            tests_run++;
            if (n_go !== 1 || n_done !== 1 || stall_bad !== 0) begin
                tests_failed++;
                $display("FAIL rand%0d_ctrl: go %0d done %0d stall_bad %0d, expected 1 1 0", b, n_go, n_done, stall_bad);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit found;
        found = 1'b0;
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; dp_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            dp_done = dp_go;
            if (out_valid && out_u == 3'd3 && out_v == 3'd5) begin found = 1'b1; break; end
        end
        tests_run++;
        if (found !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reach: address (3,5) reached %0d, expected 1", found);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, out_valid, err, out_u, out_v} !== 9'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: busy/valid/err/u/v got %b, expected 0", {busy, out_valid, err, out_u, out_v});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({busy, in_ready, buf_u, buf_v} !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_after: busy/in_ready/buf_u/buf_v got %b, expected 0", {busy, in_ready, buf_u, buf_v});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; dp_done = 1'b0; out_ready = 1'b0;
        build_drain_order();
        test_reset();
        test_full_block();
        test_stall();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
